// File: rtl/mux8_pkg.sv
// Shared definitions for the 8-to-1 mux scan sequencer.
package mux8_pkg;

    localparam int NUM_CH = 8;
    localparam int SEL_W  = 3;
    localparam int IDX_W  = 3;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } scan_state_t;

    // First select position of a frame for the given scan direction.
    function automatic logic [SEL_W-1:0] start_sel(input bit lsb_first);
        return lsb_first ? '0 : SEL_W'(NUM_CH - 1);
    endfunction

endpackage

// File: rtl/m81.sv
// 8-to-1 multiplexer built from AND/OR terms: y = d[s].
module m81 (
    input  logic [7:0] d,
    input  logic [2:0] s,
    output logic       y
);

    logic [7:0] term;

    for (genvar i = 0; i < 8; i++) begin : g_term
        assign term[i] = d[i] & (s == 3'(i));
    end

    assign y = |term;

endmodule

// File: rtl/scan_dwell_timer.sv
// Dwell counter: counts 0..DWELL-1 while enabled and flags the last count.
module scan_dwell_timer #(
    parameter int DWELL = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic load_i,
    input  logic en_i,
    output logic tick_o
);

    localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DWELL - 1);

    logic [CNT_W-1:0] cnt_q;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= '0;
        end else if (en_i) begin
            cnt_q <= (cnt_q == LAST) ? '0 : cnt_q + CNT_W'(1);
        end
    end

    assign tick_o = en_i && (cnt_q == LAST);

endmodule

// File: rtl/mux8_scan_ctrl.sv
// Accepts a byte, walks the m81 select through all eight inputs and
// re-emits the sampled mux output as a framed serial stream.
module mux8_scan_ctrl
    import mux8_pkg::*;
#(
    parameter int DWELL     = 1,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [NUM_CH-1:0] mux_d,
    output logic [SEL_W-1:0]  mux_sel,
    input  logic              mux_out,
    output logic              ser_bit,
    output logic              ser_valid,
    output logic              ser_first,
    output logic              ser_last,
    output logic              busy
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CH - 1);

    scan_state_t       state_q, state_d;
    logic [NUM_CH-1:0] data_q, data_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              sbit_q, sbit_d;
    logic              sval_q, sval_d;
    logic              sfirst_q, sfirst_d;
    logic              slast_q, slast_d;
    logic              load;
    logic              tick;

    scan_dwell_timer #(
        .DWELL (DWELL)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .load_i (load),
        .en_i   (state_q == SCAN),
        .tick_o (tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every signal gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d  = state_q;
        data_d   = data_q;
        sel_d    = sel_q;
        idx_d    = idx_q;
        sbit_d   = sbit_q;
        sval_d   = 1'b0;
        sfirst_d = 1'b0;
        slast_d  = 1'b0;
        load     = 1'b0;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    data_d  = in_data;
                    sel_d   = start_sel(LSB_FIRST);
                    idx_d   = '0;
                    load    = 1'b1;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                if (tick) begin
                    sbit_d   = mux_out;
                    sval_d   = 1'b1;
                    sfirst_d = (idx_q == '0);
                    slast_d  = (idx_q == LAST_IDX);
                    if (idx_q == LAST_IDX) begin
                        // Select is left parked on the final position.
                        state_d = IDLE;
                    end else begin
                        sel_d = LSB_FIRST ? sel_q + SEL_W'(1) : sel_q - SEL_W'(1);
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q   <= '0;
            sel_q    <= '0;
            idx_q    <= '0;
            sbit_q   <= 1'b0;
            sval_q   <= 1'b0;
            sfirst_q <= 1'b0;
            slast_q  <= 1'b0;
        end else begin
            data_q   <= data_d;
            sel_q    <= sel_d;
            idx_q    <= idx_d;
            sbit_q   <= sbit_d;
            sval_q   <= sval_d;
            sfirst_q <= sfirst_d;
            slast_q  <= slast_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q == SCAN);
    assign mux_d     = data_q;
    assign mux_sel   = sel_q;
    assign ser_bit   = sbit_q;
    assign ser_valid = sval_q;
    assign ser_first = sfirst_q;
    assign ser_last  = slast_q;

endmodule

// File: tb/tb_mux8_scan_ctrl.sv
// Bench for mux8_scan_ctrl: three configurations, each driving an m81,
// checked every cycle against a frame-timing model of the serial stream.
module tb_mux8_scan_ctrl;

    localparam int NU = 3;
    localparam int DW [NU] = '{1, 1, 3};
    localparam bit LF [NU] = '{1'b1, 1'b0, 1'b1};

    localparam int M_SINGLE = 0;
    localparam int M_HOLD   = 1;
    localparam int M_TOGGLE = 2;

    logic clk = 1'b0;
    logic rst;

    logic [NU-1:0][7:0] in_data;
    logic [NU-1:0]      in_valid;
    logic [NU-1:0]      in_ready;
    logic [NU-1:0][7:0] mux_d;
    logic [NU-1:0][2:0] mux_sel;
    logic [NU-1:0]      mux_out;
    logic [NU-1:0]      ser_bit;
    logic [NU-1:0]      ser_valid;
    logic [NU-1:0]      ser_first;
    logic [NU-1:0]      ser_last;
    logic [NU-1:0]      busy;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < NU; g++) begin : g_unit
        mux8_scan_ctrl #(
            .DWELL     (DW[g]),
            .LSB_FIRST (LF[g])
        ) u_dut (
            .clk       (clk),
            .rst       (rst),
            .in_data   (in_data[g]),
            .in_valid  (in_valid[g]),
            .in_ready  (in_ready[g]),
            .mux_d     (mux_d[g]),
            .mux_sel   (mux_sel[g]),
            .mux_out   (mux_out[g]),
            .ser_bit   (ser_bit[g]),
            .ser_valid (ser_valid[g]),
            .ser_first (ser_first[g]),
            .ser_last  (ser_last[g]),
            .busy      (busy[g])
        );

        m81 u_mux (
            .d (mux_d[g]),
            .s (mux_sel[g]),
            .y (mux_out[g])
        );
    end

    // Checks one unit is in its post-reset state.
    task automatic expect_reset_state(input int u, input string tag);
        logic [5:0] obs;
        obs = {in_ready[u], busy[u], ser_valid[u], ser_first[u], ser_last[u], ser_bit[u]};
        checks++;
        if (obs !== 6'b100000) begin
            errors++;
            $display("FAIL %s u%0d rdy/busy/v/f/l/bit: got %b required 100000", tag, u, obs);
        end
        checks++;
        if (mux_d[u] !== 8'h00) begin
            errors++;
            $display("FAIL %s u%0d mux_d: got %h required 00", tag, u, mux_d[u]);
        end
        checks++;
        if (mux_sel[u] !== 3'd0) begin
            errors++;
            $display("FAIL %s u%0d mux_sel: got %0d required 0", tag, u, mux_sel[u]);
        end
    endtask

    // Offers a word to unit u, then follows the frame cycle by cycle.
    // Expected behaviour comes from the frame timing rules: bit k (1..8) is
    // reported in the cycle after edge E0+k*DWELL and carries word[position k].
    // Called and returning with the bench positioned just after a negedge.
    task automatic run_frame(input int u, input logic [7:0] word, input int mode,
                             input logic [7:0] next_word, input int abort_after,
                             output logic [7:0] got, output int e0);
        int d;
        bit lf;
        int waited;
        int nval;
        int k;
        int kc;
        int pos;
        bit fire;
        logic [4:0] exp_vec;
        logic [4:0] obs_vec;
        logic [2:0] exp_sel;

        d      = DW[u];
        lf     = LF[u];
        waited = 0;
        nval   = 0;
        got    = '0;
        e0     = -1;

        in_data[u]  = word;
        in_valid[u] = 1'b1;
        while (in_ready[u] !== 1'b1) begin
            if (waited == 100) begin
                checks++;
                errors++;
                $display("FAIL handshake_timeout u%0d: in_ready=%b after 100 cycles, required 1", u, in_ready[u]);
                in_valid[u] = 1'b0;
                return;
            end
            @(negedge clk);
            waited++;
        end
        @(posedge clk);
        e0 = cyc;

        for (int n = 0; n <= 8 * d; n++) begin
            @(negedge clk);
            k       = n / d;
            kc      = (k > 7) ? 7 : k;
            fire    = (n > 0) && (n % d == 0);
            exp_sel = lf ? 3'(kc) : 3'(7 - kc);
            exp_vec = {fire, fire && (k == 1), fire && (k == 8), n < 8 * d, n >= 8 * d};
            obs_vec = {ser_valid[u], ser_first[u], ser_last[u], busy[u], in_ready[u]};

            checks++;
            if (obs_vec !== exp_vec) begin
                errors++;
                $display("FAIL frame_flags u%0d n=%0d v/f/l/busy/rdy: got %b required %b", u, n, obs_vec, exp_vec);
            end
            checks++;
            if (mux_d[u] !== word) begin
                errors++;
                $display("FAIL mux_d_hold u%0d n=%0d: got %h required %h", u, n, mux_d[u], word);
            end
            checks++;
            if (mux_sel[u] !== exp_sel) begin
                errors++;
                $display("FAIL mux_sel u%0d n=%0d: got %0d required %0d", u, n, mux_sel[u], exp_sel);
            end

            if (fire) begin
                pos = lf ? k - 1 : 8 - k;
                checks++;
                if (ser_bit[u] !== word[pos]) begin
                    errors++;
                    $display("FAIL ser_bit u%0d bit%0d (pos %0d): got %b required %b", u, k, pos, ser_bit[u], word[pos]);
                end
                got[pos] = ser_bit[u];
                nval++;
                if (abort_after != 0 && nval == abort_after) begin
                    in_valid[u] = 1'b0;
                    rst = 1'b1;
                    @(posedge clk);
                    @(negedge clk);
                    expect_reset_state(u, "mid_frame_reset");
                    rst = 1'b0;
                    @(negedge clk);
                    expect_reset_state(u, "after_reset_release");
                    return;
                end
            end

            if (mode == M_TOGGLE && n < 8 * d) begin
                in_valid[u] = 1'($urandom);
                in_data[u]  = 8'($urandom);
            end else if (mode == M_HOLD) begin
                in_data[u] = next_word;
            end else begin
                in_valid[u] = 1'b0;
            end
        end
    endtask

    task automatic test_reset();
        rst      = 1'b1;
        in_valid = '0;
        in_data  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        for (int u = 0; u < NU; u++) expect_reset_state(u, "reset");
    endtask

    task automatic test_a5_lsb();
        logic [7:0] got;
        int e0;
        run_frame(0, 8'hA5, M_SINGLE, 8'h00, 0, got, e0);
        checks++;
        if (got !== 8'hA5) begin
            errors++;
            $display("FAIL a5_lsb_word: got %h required a5", got);
        end
    endtask

    task automatic test_a5_msb();
        logic [7:0] got;
        int e0;
        run_frame(1, 8'hA5, M_SINGLE, 8'h00, 0, got, e0);
        checks++;
        if (got !== 8'hA5) begin
            errors++;
            $display("FAIL a5_msb_word: got %h required a5", got);
        end
    endtask

    task automatic test_dwell3();
        logic [7:0] got;
        int e0;
        run_frame(2, 8'h01, M_SINGLE, 8'h00, 0, got, e0);
        checks++;
        if (got !== 8'h01) begin
            errors++;
            $display("FAIL dwell3_word: got %h required 01", got);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] got_a;
        logic [7:0] got_b;
        int e0_a;
        int e0_b;
        run_frame(0, 8'hFF, M_HOLD, 8'h00, 0, got_a, e0_a);
        run_frame(0, 8'h00, M_SINGLE, 8'h00, 0, got_b, e0_b);
        checks++;
        if ({got_a, got_b} !== 16'hFF00) begin
            errors++;
            $display("FAIL b2b_words: got %h %h required ff 00", got_a, got_b);
        end
        checks++;
        if (e0_b - e0_a !== 9) begin
            errors++;
            $display("FAIL b2b_period: got %0d cycles required 9", e0_b - e0_a);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] got;
        int e0;
        run_frame(0, 8'hC3, M_SINGLE, 8'h00, 4, got, e0);
        run_frame(0, 8'h3C, M_SINGLE, 8'h00, 0, got, e0);
        checks++;
        if (got !== 8'h3C) begin
            errors++;
            $display("FAIL post_reset_word: got %h required 3c", got);
        end
    endtask

    task automatic test_valid_toggle();
        logic [7:0] got;
        logic [7:0] word;
        int e0;
        for (int u = 0; u < NU; u++) begin
            word = 8'($urandom);
            run_frame(u, word, M_TOGGLE, 8'h00, 0, got, e0);
            checks++;
            if (got !== word) begin
                errors++;
                $display("FAIL toggle_word u%0d: got %h required %h", u, got, word);
            end
        end
    endtask

    task automatic test_random();
        logic [7:0] got;
        logic [7:0] word;
        int e0;
        int u;
        int mode;
        for (int i = 0; i < 12; i++) begin
            u    = int'($urandom_range(0, NU - 1));
            word = 8'($urandom);
            mode = ($urandom_range(0, 1) == 0) ? M_SINGLE : M_TOGGLE;
            repeat ($urandom_range(0, 3)) @(negedge clk);
            run_frame(u, word, mode, 8'h00, 0, got, e0);
            checks++;
            if (got !== word) begin
                errors++;
                $display("FAIL random_word #%0d u%0d: got %h required %h", i, u, got, word);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst      = 1'b1;
        in_valid = '0;
        in_data  = '0;
        test_reset();
        test_a5_lsb();
        test_a5_msb();
        test_dwell3();
        test_back_to_back();
        test_reset_mid_frame();
        test_valid_toggle();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
